// File: rtl/servo_pkg.sv
// Shared constants, state encoding and tolerance helper for the servo pulse decoder.
package servo_pkg;

    localparam int unsigned SERVO_CENTER     = 1200;
    localparam int unsigned SERVO_RIGHT      = 1600;
    localparam int unsigned DEFAULT_CLK_FREQ = 50_000_000;

    typedef enum logic [1:0] {
        StWaitLow    = 2'd0,
        StWaitRise   = 2'd1,
        StHigh       = 2'd2,
        StWaitLowErr = 2'd3
    } decoder_state_e;

    // True when |w - target| <= tol, evaluated without signed wrap.
    function automatic logic within_tol(input logic [15:0] w, input int unsigned target,
                                        input int unsigned tol);
        logic [31:0] wi;
        wi = {16'd0, w};
        return (wi + tol >= target) && (wi <= target + tol);
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for pwm_in plus a third flop for edge detection, so both edges
// see identical latency.
module pwm_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], pwm_in};
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures servo PWM high time in microseconds, flags illegal pulses and signal loss,
// and decodes centre/right positions from the last legal width.
module servo_pulse_decoder
    import servo_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int unsigned MIN_US     = 500,
    parameter int unsigned MAX_US     = 2500,
    parameter int unsigned TIMEOUT_US = 25000,
    parameter int unsigned TOL_US     = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwm_in,
    output logic [15:0] pulse_width_us,
    output logic        pulse_valid,
    output logic        range_err,
    output logic        signal_lost,
    output logic        pos_center,
    output logic        pos_right,
    output logic [1:0]  state
);

    localparam int unsigned CYC_PER_US = CLK_FREQ / 1_000_000;
    localparam int unsigned PW         = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CYC_PER_US - 1);
    localparam logic [15:0] MIN_W      = 16'(MIN_US);
    localparam logic [15:0] MAX_W      = 16'(MAX_US);
    localparam logic [15:0] OVF_W      = 16'(MAX_US + 1);
    localparam logic [15:0] TMO_W      = 16'(TIMEOUT_US);
    localparam logic [15:0] TMO_PRE_W  = 16'(TIMEOUT_US - 1);

    logic level, rise, fall;

    pwm_edge_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    decoder_state_e state_q, state_d;
    logic [1:0]     arm_q;
    logic           armed;
    logic [PW-1:0]  hi_pre_q, hi_pre_d, gap_pre_q, gap_pre_d;
    logic [15:0]    hi_us_q, hi_us_d, hi_us_now, gap_us_q, gap_us_d;
    logic [15:0]    width_q, width_d;
    logic           valid_q, valid_d, err_q, err_d, lost_q, lost_d;
    logic           center_q, center_d, right_q, right_d;
    logic           hi_tick, gap_tick, legal;

    // Synchronizer flops reset to 0, so the input level is not trusted until it has refilled.
    assign armed = (arm_q == 2'd3);

    always_comb begin
        hi_tick   = (hi_pre_q == PRE_LAST);
        hi_us_now = hi_us_q + {15'd0, hi_tick};
        legal     = (hi_us_now >= MIN_W) && (hi_us_now <= MAX_W);

        state_d  = state_q;
        hi_pre_d = hi_pre_q;
        hi_us_d  = hi_us_q;
        width_d  = width_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            StWaitLow: begin
                if (armed && !level) state_d = StWaitRise;
            end
            StWaitRise: begin
                if (rise) begin
                    state_d  = StHigh;
                    hi_pre_d = '0;
                    hi_us_d  = '0;
                end
            end
            StHigh: begin
                hi_pre_d = hi_tick ? '0 : hi_pre_q + PW'(1);
                hi_us_d  = hi_us_now;
                if (fall) begin
                    state_d = StWaitRise;
                    if (legal) begin
                        width_d = hi_us_now;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (hi_us_now == OVF_W) begin
                    err_d   = 1'b1;
                    state_d = StWaitLowErr;
                end
            end
            StWaitLowErr: begin
                if (!level) state_d = StWaitRise;
            end
            default: state_d = StWaitLow;
        endcase

        gap_tick  = (gap_pre_q == PRE_LAST);
        gap_pre_d = gap_tick ? '0 : gap_pre_q + PW'(1);
        gap_us_d  = gap_us_q;
        if (rise) begin
            gap_pre_d = '0;
            gap_us_d  = '0;
        end else if (gap_tick && gap_us_q != TMO_W) begin
            gap_us_d = gap_us_q + 16'd1;
        end

        lost_d = lost_q;
        if (valid_d) begin
            lost_d = 1'b0;
        end else if (!rise && gap_tick && gap_us_q == TMO_PRE_W) begin
            lost_d = 1'b1;
        end

        center_d = center_q;
        right_d  = right_q;
        if (valid_q) begin
            center_d = within_tol(width_q, SERVO_CENTER, TOL_US);
            right_d  = within_tol(width_q, SERVO_RIGHT, TOL_US);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StWaitLow;
            arm_q     <= 2'd0;
            hi_pre_q  <= '0;
            hi_us_q   <= '0;
            gap_pre_q <= '0;
            gap_us_q  <= '0;
            width_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            lost_q    <= 1'b1;
            center_q  <= 1'b0;
            right_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            arm_q     <= armed ? arm_q : arm_q + 2'd1;
            hi_pre_q  <= hi_pre_d;
            hi_us_q   <= hi_us_d;
            gap_pre_q <= gap_pre_d;
            gap_us_q  <= gap_us_d;
            width_q   <= width_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            lost_q    <= lost_d;
            center_q  <= center_d;
            right_q   <= right_d;
        end
    end

    assign pulse_width_us = width_q;
    assign pulse_valid    = valid_q;
    assign range_err      = err_q;
    assign signal_lost    = lost_q;
    assign pos_center     = center_q;
    assign pos_right      = right_q;
    assign state          = state_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Self-checking bench: table of directed frames, hand-written corner sequences and
// randomized frames against a width/legality reference model.
`timescale 1ns/1ps
module tb_servo_pulse_decoder;

    localparam int CF     = 2_000_000;
    localparam int DIV    = CF / 1_000_000;
    localparam int MIN    = 500;
    localparam int MAX    = 2500;
    localparam int TMO    = 4000;
    localparam int TOL    = 50;
    localparam int CENTER = 1200;
    localparam int RIGHT  = 1600;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm_in = 1'b0;
    logic [15:0] pulse_width_us;
    logic        pulse_valid, range_err, signal_lost, pos_center, pos_right;
    logic [1:0]  state;

    servo_pulse_decoder #(
        .CLK_FREQ   (CF),
        .MIN_US     (MIN),
        .MAX_US     (MAX),
        .TIMEOUT_US (TMO),
        .TOL_US     (TOL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pwm_in         (pwm_in),
        .pulse_width_us (pulse_width_us),
        .pulse_valid    (pulse_valid),
        .range_err      (range_err),
        .signal_lost    (signal_lost),
        .pos_center     (pos_center),
        .pos_right      (pos_right),
        .state          (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int valid_cnt = 0;
    int err_cnt   = 0;
    int err_cyc   = 0;
    bit both_seen = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (pulse_valid) valid_cnt <= valid_cnt + 1;
            if (range_err) begin
                err_cnt <= err_cnt + 1;
                err_cyc <= cyc;
            end
            if (pulse_valid && range_err) both_seen <= 1'b1;
        end
    end

    int total = 0;
    int bad   = 0;
    int rise_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_frame(input int hi, input int lo, output int dv, output int de);
        int v0, e0;
        @(negedge clk);
        v0 = valid_cnt;
        e0 = err_cnt;
        pwm_in = 1'b1;
        rise_cyc = cyc;
        repeat (hi) @(negedge clk);
        pwm_in = 1'b0;
        repeat (lo) @(negedge clk);
        dv = valid_cnt - v0;
        de = err_cnt - e0;
    endtask

    function automatic bit near(input int w, input int t);
        return (w - t <= TOL) && (t - w <= TOL);
    endfunction

    // Reference model state: last legal width and loss flag.
    int m_width = 0;
    bit m_lost  = 1'b1;

    task automatic model_frame(input int hi, output bit ev, output bit ee);
        int w;
        w = hi / DIV;
        ev = (w >= MIN) && (w <= MAX);
        ee = !ev;
        if (ev) begin
            m_width = w;
            m_lost  = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag, input int dv, input int de, input bit ev,
                                 input bit ee);
        check({tag, ".valid_cnt"}, dv, int'(ev));
        check({tag, ".err_cnt"}, de, int'(ee));
        check({tag, ".width"}, int'(pulse_width_us), m_width);
        check({tag, ".center"}, int'(pos_center), int'(near(m_width, CENTER)));
        check({tag, ".right"}, int'(pos_right), int'(near(m_width, RIGHT)));
        check({tag, ".lost"}, int'(signal_lost), int'(m_lost));
    endtask

    typedef struct {
        int hi;
        int lo;
        int width;
        bit v;
        bit e;
        bit c;
        bit r;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int dv, de, hi, lo, v0, e0;
        bit ev, ee;

        tbl[0]  = '{hi: 2400, lo: 200, width: 1200, v: 1, e: 0, c: 1, r: 0};
        tbl[1]  = '{hi: 2400, lo: 200, width: 1200, v: 1, e: 0, c: 1, r: 0};
        tbl[2]  = '{hi: 2400, lo: 200, width: 1200, v: 1, e: 0, c: 1, r: 0};
        tbl[3]  = '{hi: 600,  lo: 200, width: 1200, v: 0, e: 1, c: 1, r: 0};
        tbl[4]  = '{hi: 3200, lo: 200, width: 1600, v: 1, e: 0, c: 0, r: 1};
        tbl[5]  = '{hi: 3201, lo: 200, width: 1600, v: 1, e: 0, c: 0, r: 1};
        tbl[6]  = '{hi: 1000, lo: 200, width: 500,  v: 1, e: 0, c: 0, r: 0};
        tbl[7]  = '{hi: 999,  lo: 200, width: 500,  v: 0, e: 1, c: 0, r: 0};
        tbl[8]  = '{hi: 5001, lo: 200, width: 2500, v: 1, e: 0, c: 0, r: 0};
        tbl[9]  = '{hi: 2500, lo: 200, width: 1250, v: 1, e: 0, c: 1, r: 0};
        tbl[10] = '{hi: 2502, lo: 200, width: 1251, v: 1, e: 0, c: 0, r: 0};

        // Reset state
        repeat (5) @(negedge clk);
        check("rst.state", int'(state), 0);
        check("rst.width", int'(pulse_width_us), 0);
        check("rst.valid", int'(pulse_valid), 0);
        check("rst.err", int'(range_err), 0);
        check("rst.center", int'(pos_center), 0);
        check("rst.right", int'(pos_right), 0);
        check("rst.lost", int'(signal_lost), 1);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("armed.state", int'(state), 1);

        foreach (tbl[i]) begin
            run_frame(tbl[i].hi, tbl[i].lo, dv, de);
            check($sformatf("tbl%0d.valid_cnt", i), dv, int'(tbl[i].v));
            check($sformatf("tbl%0d.err_cnt", i), de, int'(tbl[i].e));
            check($sformatf("tbl%0d.width", i), int'(pulse_width_us), tbl[i].width);
            check($sformatf("tbl%0d.center", i), int'(pos_center), int'(tbl[i].c));
            check($sformatf("tbl%0d.right", i), int'(pos_right), int'(tbl[i].r));
            check($sformatf("tbl%0d.lost", i), int'(signal_lost), 0);
        end
        m_width = 1251;
        m_lost  = 1'b0;

        // Held high past MAX: early error, then parked in WAIT_LOW_ERR until low.
        @(negedge clk);
        v0 = valid_cnt;
        e0 = err_cnt;
        pwm_in = 1'b1;
        rise_cyc = cyc;
        repeat (5100) @(negedge clk);
        check("hold.state", int'(state), 3);
        check("hold.err_cnt", err_cnt - e0, 1);
        check("hold.err_at_2501us", int'((err_cyc - rise_cyc >= 5002) && (err_cyc - rise_cyc <= 5008)), 1);
        repeat (900) @(negedge clk);
        check("hold.state_late", int'(state), 3);
        pwm_in = 1'b0;
        repeat (200) @(negedge clk);
        check("hold.valid_cnt", valid_cnt - v0, 0);
        check("hold.err_total", err_cnt - e0, 1);
        check("hold.width", int'(pulse_width_us), 1251);
        check("hold.state_after", int'(state), 1);
        run_frame(3000, 200, dv, de);
        model_frame(3000, ev, ee);
        check_outputs("after_hold", dv, de, ev, ee);

        // Signal loss: low for longer than TIMEOUT after the last rise.
        while (cyc < rise_cyc + TMO * DIV - 10) @(negedge clk);
        check("lost.before", int'(signal_lost), 0);
        while (cyc < rise_cyc + TMO * DIV + 20) @(negedge clk);
        check("lost.after", int'(signal_lost), 1);
        m_lost = 1'b1;
        run_frame(2400, 200, dv, de);
        model_frame(2400, ev, ee);
        check_outputs("relock", dv, de, ev, ee);

        // Reset asserted and released mid-pulse: that pulse must be discarded.
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (400) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        v0 = valid_cnt;
        e0 = err_cnt;
        check("midrst.lost", int'(signal_lost), 1);
        repeat (2000) @(negedge clk);
        check("midrst.state_high", int'(state), 0);
        pwm_in = 1'b0;
        repeat (200) @(negedge clk);
        check("midrst.valid_cnt", valid_cnt - v0, 0);
        check("midrst.err_cnt", err_cnt - e0, 0);
        check("midrst.width", int'(pulse_width_us), 0);
        m_width = 0;
        m_lost  = 1'b1;
        run_frame(2400, 200, dv, de);
        model_frame(2400, ev, ee);
        check_outputs("midrst_next", dv, de, ev, ee);

        // Randomized frames against the model.
        for (int k = 0; k < 5; k++) begin
            hi = $urandom_range(400, 5400);
            lo = $urandom_range(200, 600);
            run_frame(hi, lo, dv, de);
            model_frame(hi, ev, ee);
            check_outputs($sformatf("rnd%0d_hi%0d", k, hi), dv, de, ev, ee);
        end

        check("valid_err_exclusive", int'(both_seen), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
